// File: rtl/sap1_ctrl_seq.sv
// rtl/sap1_ctrl_seq.sv - SAP-1 control sequencer: T1..T6 ring counter, control word decode, halt latch (optional CTRL_EARLY_FETCH_EN)
module sap1_ctrl_seq #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  opcode,
    output logic        Cp,
    output logic        Ep,
    output logic        Lm,
    output logic        Er,
    output logic        Li,
    output logic        Ei,
    output logic        La,
    output logic        Ea,
    output logic        Su,
    output logic        Eu,
    output logic        Lb,
    output logic        Lo,
    output logic [11:0] con,
    output logic [5:0]  tstate,
    output logic        hlt
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_t;

    // Bit positions inside the control word {Cp,Ep,Lm,Er,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam int B_CP = 11;
    localparam int B_EP = 10;
    localparam int B_LM = 9;
    localparam int B_ER = 8;
    localparam int B_LI = 7;
    localparam int B_EI = 6;
    localparam int B_LA = 5;
    localparam int B_EA = 4;
    localparam int B_SU = 3;
    localparam int B_EU = 2;
    localparam int B_LB = 1;
    localparam int B_LO = 0;

    // Every active-low strobe high, every active-high strobe low
    localparam logic [11:0] CON_IDLE = 12'h3E3;

    tstate_t     r_state;
    tstate_t     w_state_nxt;
    logic        r_hlt;
    logic        w_hlt_nxt;
    logic [11:0] w_con;

    // State register: ring position and halt latch, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= T1;
            r_hlt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hlt   <= w_hlt_nxt;
        end
    end

    // Next ring position; HLT latches at the end of T4 and freezes the ring there
    always_comb begin
        w_state_nxt = r_state;
        w_hlt_nxt   = r_hlt;
        if (!r_hlt) begin
            case (r_state)
                T1: w_state_nxt = T2;
                T2: w_state_nxt = T3;
                T3: w_state_nxt = T4;
                T4: begin
                    if (opcode == OP_HLT) begin
                        w_hlt_nxt = 1'b1;
`ifdef CTRL_EARLY_FETCH_EN
                    end else if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        w_state_nxt = T5;
                    end else begin
                        // OUT and undefined opcodes have nothing left to do after T4
                        w_state_nxt = T1;
`else
                    end else begin
                        w_state_nxt = T5;
`endif
                    end
                end
`ifdef CTRL_EARLY_FETCH_EN
                T5: w_state_nxt = (opcode == OP_LDA) ? T1 : T6;
`else
                T5: w_state_nxt = T6;
`endif
                T6: w_state_nxt = T1;
                default: w_state_nxt = T1;
            endcase
        end
    end

    // Control word decode; forced idle while reset is held or the CPU is halted
    always_comb begin
        w_con = CON_IDLE;
        if (!RST && !r_hlt) begin
            case (r_state)
                T1: begin
                    w_con[B_EP] = 1'b1;
                    w_con[B_LM] = 1'b0;
                end
                T2: w_con[B_CP] = 1'b1;
                T3: begin
                    w_con[B_ER] = 1'b0;
                    w_con[B_LI] = 1'b0;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        w_con[B_EI] = 1'b0;
                        w_con[B_LM] = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        w_con[B_EA] = 1'b1;
                        w_con[B_LO] = 1'b0;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        w_con[B_ER] = 1'b0;
                        w_con[B_LA] = 1'b0;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_con[B_ER] = 1'b0;
                        w_con[B_LB] = 1'b0;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        w_con[B_EU] = 1'b1;
                        w_con[B_LA] = 1'b0;
                        w_con[B_SU] = (opcode == OP_SUB);
                    end
                end
                default: w_con = CON_IDLE;
            endcase
        end
    end

    assign Cp     = w_con[B_CP];
    assign Ep     = w_con[B_EP];
    assign Lm     = w_con[B_LM];
    assign Er     = w_con[B_ER];
    assign Li     = w_con[B_LI];
    assign Ei     = w_con[B_EI];
    assign La     = w_con[B_LA];
    assign Ea     = w_con[B_EA];
    assign Su     = w_con[B_SU];
    assign Eu     = w_con[B_EU];
    assign Lb     = w_con[B_LB];
    assign Lo     = w_con[B_LO];
    assign con    = w_con;
    assign tstate = r_state;
    assign hlt    = r_hlt;

endmodule
